// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one synchronous single-port RAM between an
// instruction-fetch port and a data load/store port.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   if_req_i/if_addr_i                   fetch request (held until if_valid_o)
//   if_rdata_o/if_valid_o                fetch result and one-cycle completion pulse
//   d_req_i/d_we_i/d_addr_i/d_wdata_i    data request (held until d_valid_o)
//   d_rdata_o/d_valid_o                  load result and one-cycle completion pulse
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_rdata_i   RAM side
//   stall_o           some request is pending and is not completing this cycle
//   conflict_cnt_o    saturating count of IDLE cycles with both requests
//
// Each access takes two cycles: an issue cycle in IDLE, then a response
// cycle in BUSY_IF/BUSY_D while the RAM returns data.
module core_mem_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic                  if_valid_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  d_valid_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  stall_o,
  output logic [15:0]           conflict_cnt_o
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;
  typedef enum logic {GRANT_IF, GRANT_D} grant_t;

  state_t                state_q, state_d;
  grant_t                last_grant_q, last_grant_d;
  logic                  d_we_q;
  logic [DATA_WIDTH-1:0] if_hold_q;
  logic [DATA_WIDTH-1:0] d_hold_q;
  logic [15:0]           conflict_cnt_q;

  logic conflict;
  logic grant_if;
  logic grant_d;

  // Round-robin: on a conflict the port that did not win last time wins.
  always_comb begin
    conflict = (state_q == IDLE) && if_req_i && d_req_i;
    grant_if = (state_q == IDLE) && if_req_i && (!d_req_i || (last_grant_q == GRANT_D));
    grant_d  = (state_q == IDLE) && d_req_i && (!if_req_i || (last_grant_q == GRANT_IF));
  end

  // State register plus the registers that ride along with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      last_grant_q   <= GRANT_D;
      d_we_q         <= 1'b0;
      if_hold_q      <= '0;
      d_hold_q       <= '0;
      conflict_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      if (grant_d) begin
        d_we_q <= d_we_i;
      end
      if (state_q == BUSY_IF) begin
        if_hold_q <= mem_rdata_i;
      end
      if ((state_q == BUSY_D) && !d_we_q) begin
        d_hold_q <= mem_rdata_i;
      end
      if (conflict && (conflict_cnt_q != 16'hFFFF)) begin
        conflict_cnt_q <= conflict_cnt_q + 16'd1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (grant_if) begin
          state_d = BUSY_IF;
        end else if (grant_d) begin
          state_d = BUSY_D;
        end
        if (conflict) begin
          last_grant_d = grant_if ? GRANT_IF : GRANT_D;
        end
      end
      BUSY_IF: state_d = IDLE;
      BUSY_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs. Reset masks issue and completion so an access in flight is
  // dropped without a valid pulse.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if_valid_o  = 1'b0;
    d_valid_o   = 1'b0;
    if_rdata_o  = if_hold_q;
    d_rdata_o   = d_hold_q;
    if (!rst) begin
      if (grant_if) begin
        mem_en_o   = 1'b1;
        mem_addr_o = if_addr_i;
      end else if (grant_d) begin
        mem_en_o   = 1'b1;
        mem_we_o   = d_we_i;
        mem_addr_o = d_addr_i;
        if (d_we_i) begin
          mem_wdata_o = d_wdata_i;
        end
      end
      if (state_q == BUSY_IF) begin
        if_valid_o = 1'b1;
        if_rdata_o = mem_rdata_i;
      end
      if (state_q == BUSY_D) begin
        d_valid_o = 1'b1;
        if (!d_we_q) begin
          d_rdata_o = mem_rdata_i;
        end
      end
    end
    stall_o        = (if_req_i & ~if_valid_o) | (d_req_i & ~d_valid_o);
    conflict_cnt_o = conflict_cnt_q;
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Testbench for core_mem_arbiter: directed table, hand-written corner
// sequences and a randomized run against a transaction-level model.
module tb_core_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          stall;
  logic [15:0]   conflict_cnt;

  core_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_valid_o(if_valid),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_rdata_o(d_rdata), .d_valid_o(d_valid),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .stall_o(stall), .conflict_cnt_o(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(int unsigned a);
    if (a == 4) return 32'h00500093;
    return 32'hA500_0000 | (a * 32'h0000_0103);
  endfunction

  // Synchronous single-port RAM, read data one cycle after issue.
  logic          ram_init;
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= init_word(i);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  int total;
  int bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; ram_init = 1'b1;
    @(negedge clk);
    rst = 1'b0; ram_init = 1'b0;
  endtask

  typedef struct {
    logic          if_req;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] if_addr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] wdata;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    int            win;      // 0 none, 1 fetch, 2 data
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  // model state for the randomized run
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            inflight;
  logic          infl_we;
  logic [DW-1:0] infl_data;
  logic          last_was_d;
  logic [DW-1:0] m_if_hold, m_d_hold;
  int            m_cnt;
  logic          if_done, d_done;

  initial begin
    logic [DW-1:0] if_hold, d_hold;
    total = 0; bad = 0;
    rst = 1'b1; ram_init = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 32'h0,        1'b0, 10'h000, 32'h0,        0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 10'h004, 10'h000, 32'h0,        1'b0, 10'h004, 32'h0,        1, 32'h00500093};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 10'h000, 10'h010, 32'hDEADBEEF, 1'b1, 10'h010, 32'hDEADBEEF, 2, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 10'h000, 10'h010, 32'h12345678, 1'b0, 10'h010, 32'h0,        2, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 10'h005, 10'h010, 32'h0,        1'b0, 10'h005, 32'h0,        1, init_word(5)};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 10'h005, 10'h010, 32'h0,        1'b0, 10'h010, 32'h0,        2, 32'hDEADBEEF};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 10'h004, 10'h020, 32'hCAFEF00D, 1'b0, 10'h004, 32'h0,        1, 32'h00500093};

    // reset: strobes and valids forced low even with requests present
    @(negedge clk);
    ram_init = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_d_valid", d_valid, 0);
    @(negedge clk);
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    #1;
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_cnt", conflict_cnt, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_stall", stall, 0);

    // directed table
    if_hold = '0; d_hold = '0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if_req = vecs[i].if_req; d_req = vecs[i].d_req; d_we = vecs[i].d_we;
      if_addr = vecs[i].if_addr; d_addr = vecs[i].d_addr; d_wdata = vecs[i].wdata;
      #1;
      chk($sformatf("v%0d_mem_en", i), mem_en, vecs[i].win != 0);
      chk($sformatf("v%0d_mem_we", i), mem_we, vecs[i].exp_we);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].exp_wdata);
      chk($sformatf("v%0d_stall_issue", i), stall, vecs[i].if_req | vecs[i].d_req);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_if_valid", i), if_valid, vecs[i].win == 1);
      chk($sformatf("v%0d_d_valid", i), d_valid, vecs[i].win == 2);
      chk($sformatf("v%0d_if_rdata", i), if_rdata, (vecs[i].win == 1) ? vecs[i].exp_rdata : if_hold);
      chk($sformatf("v%0d_d_rdata", i), d_rdata,
          (vecs[i].win == 2 && !vecs[i].d_we) ? vecs[i].exp_rdata : d_hold);
      chk($sformatf("v%0d_stall_resp", i), stall,
          (vecs[i].if_req && vecs[i].win != 1) || (vecs[i].d_req && vecs[i].win != 2));
      if (vecs[i].win == 1) if_hold = vecs[i].exp_rdata;
      if (vecs[i].win == 2 && !vecs[i].d_we) d_hold = vecs[i].exp_rdata;
      @(negedge clk);
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      #1;
      chk($sformatf("v%0d_if_hold", i), if_rdata, if_hold);
      chk($sformatf("v%0d_d_hold", i), d_rdata, d_hold);
      chk($sformatf("v%0d_idle_en", i), mem_en, 0);
    end
    chk("table_cnt", conflict_cnt, 3);

    // reset during the response cycle of a read aborts it
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h005;
    #1;
    chk("abort_issue", mem_en, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_no_valid", d_valid, 0);
    chk("abort_mem_en", mem_en, 0);
    @(negedge clk);
    rst = 1'b0; d_req = 1'b0;
    #1;
    chk("abort_d_valid", d_valid, 0);
    chk("abort_if_rdata", if_rdata, 0);
    chk("abort_d_rdata", d_rdata, 0);
    chk("abort_cnt", conflict_cnt, 0);
    chk("abort_mem_en2", mem_en, 0);
    chk("abort_stall", stall, 0);

    // fetch only: stall on issue, clear on the valid cycle
    @(negedge clk);
    if_req = 1'b1; if_addr = 10'h004;
    #1;
    chk("fonly_issue_en", mem_en, 1);
    chk("fonly_issue_stall", stall, 1);
    @(negedge clk);
    #1;
    chk("fonly_valid", if_valid, 1);
    chk("fonly_rdata", if_rdata, 32'h00500093);
    chk("fonly_stall", stall, 0);

    // both held from reset: IF, D, IF, D
    do_reset();
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 10'h030; d_addr = 10'h031;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk($sformatf("rr%0d_en", g), mem_en, 1);
      chk($sformatf("rr%0d_addr", g), mem_addr, (g % 2 == 0) ? 32'h30 : 32'h31);
      chk($sformatf("rr%0d_stall_issue", g), stall, 1);
      @(negedge clk);
      #1;
      chk($sformatf("rr%0d_if_valid", g), if_valid, g % 2 == 0);
      chk($sformatf("rr%0d_d_valid", g), d_valid, g % 2 == 1);
      chk($sformatf("rr%0d_stall_resp", g), stall, 1);
      @(negedge clk);
    end
    #1;
    chk("rr_cnt", conflict_cnt, 4);
    if_req = 1'b0; d_req = 1'b0;

    // both pending: stall stays high until the second completes
    @(negedge clk);
    if_req = 1'b1; d_req = 1'b1;
    #1;
    chk("bp_issue_addr", mem_addr, 32'h30);
    chk("bp_issue_stall", stall, 1);
    @(negedge clk);
    #1;
    chk("bp_if_valid", if_valid, 1);
    chk("bp_if_stall", stall, 1);
    @(negedge clk);
    if_req = 1'b0;
    #1;
    chk("bp_d_addr", mem_addr, 32'h31);
    chk("bp_d_stall", stall, 1);
    @(negedge clk);
    #1;
    chk("bp_d_valid", d_valid, 1);
    chk("bp_d_stall_done", stall, 0);
    @(negedge clk);
    d_req = 1'b0;

    // request withdrawn before completion still completes
    @(negedge clk);
    if_req = 1'b1; if_addr = 10'h004;
    @(negedge clk);
    if_req = 1'b0;
    #1;
    chk("drop_valid", if_valid, 1);
    chk("drop_stall", stall, 0);

    // randomized run against the transaction model
    do_reset();
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
    inflight = 0; infl_we = 1'b0; infl_data = '0; last_was_d = 1'b1;
    m_if_hold = '0; m_d_hold = '0; m_cnt = 0; if_done = 1'b0; d_done = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int win;
      logic e_en, e_we, e_ifv, e_dv, e_stall;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd, e_ifr, e_dr;
      int e_cnt;
      @(negedge clk);
      if (!if_req || if_done) begin
        if_done = 1'b0;
        if_req = ($urandom_range(0, 2) != 0);
        if_addr = AW'($urandom_range(0, 15));
      end
      if (!d_req || d_done) begin
        d_done = 1'b0;
        d_req = ($urandom_range(0, 2) != 0);
        d_we = $urandom_range(0, 1) == 1;
        d_addr = AW'($urandom_range(0, 15));
        d_wdata = $urandom;
      end
      #1;
      win = 0; e_en = 0; e_we = 0; e_addr = '0; e_wd = '0; e_ifv = 0; e_dv = 0;
      e_ifr = m_if_hold; e_dr = m_d_hold; e_cnt = m_cnt;
      if (inflight == 1) begin
        e_ifv = 1; e_ifr = infl_data;
      end else if (inflight == 2) begin
        e_dv = 1;
        if (!infl_we) e_dr = infl_data;
      end else begin
        if (if_req && d_req) begin
          win = last_was_d ? 1 : 2;
          last_was_d = (win == 2);
          if (m_cnt < 65535) m_cnt++;
        end else if (if_req) win = 1;
        else if (d_req) win = 2;
        if (win == 1) begin
          e_en = 1; e_addr = if_addr;
        end else if (win == 2) begin
          e_en = 1; e_addr = d_addr; e_we = d_we;
          if (d_we) e_wd = d_wdata;
        end
      end
      e_stall = (if_req && !e_ifv) || (d_req && !e_dv);
      chk("rnd_mem_en", mem_en, e_en);
      chk("rnd_mem_we", mem_we, e_we);
      chk("rnd_mem_addr", mem_addr, e_addr);
      chk("rnd_mem_wdata", mem_wdata, e_wd);
      chk("rnd_if_valid", if_valid, e_ifv);
      chk("rnd_d_valid", d_valid, e_dv);
      chk("rnd_if_rdata", if_rdata, e_ifr);
      chk("rnd_d_rdata", d_rdata, e_dr);
      chk("rnd_stall", stall, e_stall);
      chk("rnd_cnt", conflict_cnt, e_cnt);
      if (inflight != 0) begin
        if (e_ifv) begin m_if_hold = e_ifr; if_done = 1'b1; end
        if (e_dv)  begin m_d_hold = e_dr;  d_done = 1'b1; end
        inflight = 0;
      end else if (win == 1) begin
        inflight = 1; infl_data = ref_mem[if_addr];
      end else if (win == 2) begin
        inflight = 2; infl_we = d_we;
        if (d_we) ref_mem[d_addr] = d_wdata;
        else      infl_data = ref_mem[d_addr];
      end
    end

    // saturation from a preset value
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);
    force dut.conflict_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.conflict_cnt_q;
    #1;
    chk("sat_preset", conflict_cnt, 16'hFFFE);
    @(negedge clk);
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    repeat (5) @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    #1;
    chk("sat_value", conflict_cnt, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
